// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register sitting directly in front of the ALU. Each load
// edge captures the decoded instruction fields from ID. The ALU control code
// and the destination register are resolved at load time and registered.
// Operands are forwarded combinationally from the EX/MEM and MEM/WB stages.
//
// Hazard control, in priority order per edge: rst_i > flush_i > stall_i > load
//   flush_i : load a bubble (all fields zero, alu_ctl = ADD)
//   stall_i : every register keeps its value
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   stall_i, flush_i      hazard-unit hold / bubble request
//   id_*                  decoded instruction fields from the ID stage
//   exmem_*, memwb_*      forwarding sources from the later stages
//   alu_ctl_o             registered 4-bit ALU control code
//   alu_a_o, alu_b_o      ALU operands after forwarding / immediate select
//   store_data_o          forwarded rt value, used as store data
//   wr_reg_o              registered destination register
//   reg_write_o .. mem_to_reg_o  registered control pass-through
//   valid_o               EX slot holds a real instruction
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs_data_i,
  input  logic [DW-1:0] id_rt_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic [RW-1:0] id_rd_i,
  input  logic [2:0]    id_alu_op_i,
  input  logic [5:0]    id_funct_i,
  input  logic          id_alu_src_i,
  input  logic          id_reg_dst_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          id_mem_to_reg_i,
  input  logic          exmem_reg_write_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [3:0]    alu_ctl_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] wr_reg_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          mem_to_reg_o,
  output logic          valid_o
);

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_MUL = 4'd3;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;
  localparam logic [3:0] CTL_ZERO = 4'd15;  // ALU drives 0 for this code

  // Registered fields
  logic          valid_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] wr_reg_q;
  logic [3:0]    alu_ctl_q;
  logic          alu_src_q;
  logic          reg_write_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          mem_to_reg_q;

  // ALU control decode from the ID-stage fields, registered on load.
  logic [3:0] dec_ctl;

  always_comb begin
    dec_ctl = CTL_ZERO;
    unique case (id_alu_op_i)
      3'b000: dec_ctl = CTL_ADD;
      3'b001: dec_ctl = CTL_SUB;
      3'b011: dec_ctl = CTL_SLT;
      3'b100: dec_ctl = CTL_AND;
      3'b101: dec_ctl = CTL_OR;
      3'b010: begin
        case (id_funct_i)
          6'h20:   dec_ctl = CTL_ADD;
          6'h22:   dec_ctl = CTL_SUB;
          6'h24:   dec_ctl = CTL_AND;
          6'h25:   dec_ctl = CTL_OR;
          6'h27:   dec_ctl = CTL_NOR;
          6'h2A:   dec_ctl = CTL_SLT;
          6'h18:   dec_ctl = CTL_MUL;
          default: dec_ctl = CTL_ZERO;
        endcase
      end
      default: dec_ctl = CTL_ZERO;  // 110, 111
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      // Reset and bubble share one image: nothing valid, rs = rt = 0 so
      // no forwarding source can ever match the empty slot.
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wr_reg_q     <= '0;
      alu_ctl_q    <= CTL_ADD;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q      <= id_valid_i;
      rs_data_q    <= id_rs_data_i;
      rt_data_q    <= id_rt_data_i;
      imm_q        <= id_imm_i;
      rs_q         <= id_rs_i;
      rt_q         <= id_rt_i;
      wr_reg_q     <= id_reg_dst_i ? id_rd_i : id_rt_i;
      alu_ctl_q    <= dec_ctl;
      alu_src_q    <= id_alu_src_i;
      reg_write_q  <= id_reg_write_i;
      mem_read_q   <= id_mem_read_i;
      mem_write_q  <= id_mem_write_i;
      mem_to_reg_q <= id_mem_to_reg_i;
    end
  end

  // Forwarding: EX/MEM is the younger result and wins over MEM/WB.
  // Register 0 is hardwired and never forwarded. This tracks the live
  // exmem/memwb inputs, so operands can change while stalled.
  logic          exmem_fwd_rs, exmem_fwd_rt;
  logic          memwb_fwd_rs, memwb_fwd_rt;
  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    exmem_fwd_rs = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_q);
    exmem_fwd_rt = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rt_q);
    memwb_fwd_rs = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_q);
    memwb_fwd_rt = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rt_q);

    if (exmem_fwd_rs)      fwd_rs = exmem_result_i;
    else if (memwb_fwd_rs) fwd_rs = memwb_result_i;
    else                   fwd_rs = rs_data_q;

    if (exmem_fwd_rt)      fwd_rt = exmem_result_i;
    else if (memwb_fwd_rt) fwd_rt = memwb_result_i;
    else                   fwd_rt = rt_data_q;
  end

  assign alu_a_o      = fwd_rs;
  assign alu_b_o      = alu_src_q ? imm_q : fwd_rt;
  assign store_data_o = fwd_rt;
  assign alu_ctl_o    = alu_ctl_q;
  assign wr_reg_o     = wr_reg_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage: a decode vector table, hand-written
// sequences for forwarding, stall, flush and reset, and a randomized run
// checked against a reference model of the EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst, stall, flush;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic          id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [2:0]    id_alu_op;
  logic [5:0]    id_funct;
  logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write, memwb_reg_write;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [3:0]    alu_ctl;
  logic [DW-1:0] alu_a, alu_b, store_data;
  logic [RW-1:0] wr_reg;
  logic          reg_write, mem_read, mem_write, mem_to_reg, valid;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data),
    .id_imm_i(id_imm), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_alu_op_i(id_alu_op), .id_funct_i(id_funct), .id_alu_src_i(id_alu_src),
    .id_reg_dst_i(id_reg_dst), .id_reg_write_i(id_reg_write),
    .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write),
    .id_mem_to_reg_i(id_mem_to_reg),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .alu_ctl_o(alu_ctl), .alu_a_o(alu_a), .alu_b_o(alu_b), .store_data_o(store_data),
    .wr_reg_o(wr_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg), .valid_o(valid)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the raw instruction captured in the EX slot and derives
  // every output from it on demand.
  typedef struct {
    logic          v;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [RW-1:0] rs, rt, rd;
    logic [2:0]    op;
    logic [5:0]    funct;
    logic          alu_src, reg_dst, rw, mr, mw, m2r;
  } slot_t;

  slot_t m;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.rs_data = 0; s.rt_data = 0; s.imm = 0;
    s.rs = 0; s.rt = 0; s.rd = 0; s.op = 3'b000; s.funct = 0;
    s.alu_src = 0; s.reg_dst = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0;
    return s;
  endfunction

  function automatic logic [3:0] ref_ctl(input logic [2:0] op, input logic [5:0] f);
    if (op == 3'b000) return 4'd2;
    if (op == 3'b001) return 4'd6;
    if (op == 3'b011) return 4'd7;
    if (op == 3'b100) return 4'd0;
    if (op == 3'b101) return 4'd1;
    if (op == 3'b010) begin
      if (f == 6'h20) return 4'd2;
      if (f == 6'h22) return 4'd6;
      if (f == 6'h24) return 4'd0;
      if (f == 6'h25) return 4'd1;
      if (f == 6'h27) return 4'd12;
      if (f == 6'h2A) return 4'd7;
      if (f == 6'h18) return 4'd3;
    end
    return 4'd15;
  endfunction

  function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] r, input logic [DW-1:0] d);
    if (r == 0) return d;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  // Sample inputs as the DUT will see them at the next edge.
  task automatic model_update();
    if (rst || flush) m = empty_slot();
    else if (!stall) begin
      m.v = id_valid; m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.op = id_alu_op; m.funct = id_funct;
      m.alu_src = id_alu_src; m.reg_dst = id_reg_dst; m.rw = id_reg_write;
      m.mr = id_mem_read; m.mw = id_mem_write; m.m2r = id_mem_to_reg;
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] a_exp, rt_exp;
    a_exp  = ref_fwd(m.rs, m.rs_data);
    rt_exp = ref_fwd(m.rt, m.rt_data);
    check({tag, ".valid"},      valid,      m.v);
    check({tag, ".alu_ctl"},    alu_ctl,    ref_ctl(m.op, m.funct));
    check({tag, ".alu_a"},      alu_a,      a_exp);
    check({tag, ".alu_b"},      alu_b,      m.alu_src ? m.imm : rt_exp);
    check({tag, ".store_data"}, store_data, rt_exp);
    check({tag, ".wr_reg"},     wr_reg,     m.reg_dst ? m.rd : m.rt);
    check({tag, ".ctrl"}, {reg_write, mem_read, mem_write, mem_to_reg}, {m.rw, m.mr, m.mw, m.m2r});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random_id();
    id_valid      = 1'($urandom_range(0, 1));
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    id_rs         = RW'($urandom_range(0, 7));
    id_rt         = RW'($urandom_range(0, 7));
    id_rd         = RW'($urandom_range(0, 31));
    id_alu_op     = 3'($urandom_range(0, 7));
    id_funct      = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'h20 + 6'($urandom_range(0, 10));
    id_alu_src    = 1'($urandom_range(0, 1));
    id_reg_dst    = 1'($urandom_range(0, 1));
    id_reg_write  = 1'($urandom_range(0, 1));
    id_mem_read   = 1'($urandom_range(0, 1));
    id_mem_write  = 1'($urandom_range(0, 1));
    id_mem_to_reg = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_random_fwd();
    exmem_reg_write = 1'($urandom_range(0, 1));
    exmem_rd        = RW'($urandom_range(0, 7));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom_range(0, 1));
    memwb_rd        = RW'($urandom_range(0, 7));
    memwb_result    = $urandom;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [2:0] op;
    logic [5:0] funct;
    logic [3:0] exp_ctl;
  } dec_vec_t;

  dec_vec_t dec_tab[16];

  // ---------------- main test ----------------
  initial begin
    rst = 1; stall = 0; flush = 0;
    drive_random_id();
    no_fwd();
    m = empty_slot();

    dec_tab[0]  = '{3'b000, 6'h22, 4'd2};
    dec_tab[1]  = '{3'b001, 6'h20, 4'd6};
    dec_tab[2]  = '{3'b011, 6'h00, 4'd7};
    dec_tab[3]  = '{3'b100, 6'h25, 4'd0};
    dec_tab[4]  = '{3'b101, 6'h24, 4'd1};
    dec_tab[5]  = '{3'b110, 6'h20, 4'd15};
    dec_tab[6]  = '{3'b111, 6'h20, 4'd15};
    dec_tab[7]  = '{3'b010, 6'h20, 4'd2};
    dec_tab[8]  = '{3'b010, 6'h22, 4'd6};
    dec_tab[9]  = '{3'b010, 6'h24, 4'd0};
    dec_tab[10] = '{3'b010, 6'h25, 4'd1};
    dec_tab[11] = '{3'b010, 6'h27, 4'd12};
    dec_tab[12] = '{3'b010, 6'h2A, 4'd7};
    dec_tab[13] = '{3'b010, 6'h18, 4'd3};
    dec_tab[14] = '{3'b010, 6'h3F, 4'd15};
    dec_tab[15] = '{3'b010, 6'h00, 4'd15};

    // Reset for two cycles with random ID inputs
    step();
    drive_random_id();
    step();
    check("reset.valid", valid, 0);
    check("reset.alu_ctl", alu_ctl, 4'd2);
    check("reset.ctrl", {reg_write, mem_read, mem_write, mem_to_reg}, 0);
    check("reset.alu_a", alu_a, 0);
    check("reset.wr_reg", wr_reg, 0);
    check_all("reset");
    rst = 0;

    // R-type NOR, no forwarding
    id_valid = 1; id_alu_op = 3'b010; id_funct = 6'h27;
    id_rs_data = 32'h0F0F0000; id_rt_data = 32'h00FF00FF; id_imm = 32'h1234;
    id_rs = 3; id_rt = 4; id_rd = 9; id_reg_dst = 1; id_alu_src = 0;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    step();
    check("nor.alu_ctl", alu_ctl, 4'd12);
    check("nor.alu_a", alu_a, 32'h0F0F0000);
    check("nor.alu_b", alu_b, 32'h00FF00FF);
    check("nor.wr_reg", wr_reg, 9);
    check_all("nor");

    // Decode sweep from the table
    for (int i = 0; i < 16; i++) begin
      id_alu_op = dec_tab[i].op;
      id_funct  = dec_tab[i].funct;
      step();
      check($sformatf("dec[%0d]", i), alu_ctl, dec_tab[i].exp_ctl);
      check_all($sformatf("dec[%0d]", i));
    end
    // Exhaustive R-type funct sweep against the model
    for (int f = 0; f < 64; f++) begin
      id_alu_op = 3'b010;
      id_funct  = 6'(f);
      step();
      check_all($sformatf("funct[%0d]", f));
    end

    // Double forward
    id_alu_op = 3'b000; id_rs = 5; id_rt = 5; id_alu_src = 0;
    id_rs_data = 32'hAAAA0001; id_rt_data = 32'hBBBB0002;
    step();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h22;
    #1;
    check("dfwd.both", alu_a, 32'h11);
    check_all("dfwd.both");
    exmem_reg_write = 0;
    #1;
    check("dfwd.memwb", alu_a, 32'h22);
    check_all("dfwd.memwb");
    exmem_reg_write = 1;
    id_rs = 0; id_rt = 0; exmem_rd = 0; memwb_rd = 0;
    step();
    check("dfwd.r0", alu_a, 32'hAAAA0001);
    check("dfwd.r0_store", store_data, 32'hBBBB0002);
    check_all("dfwd.r0");

    // Immediate select with forwarded rt
    id_alu_src = 1; id_imm = 32'hFFFFFFFC; id_rt = 7; id_rs = 1;
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'h33;
    step();
    check("imm.alu_b", alu_b, 32'hFFFFFFFC);
    check("imm.store", store_data, 32'h33);
    check_all("imm");

    // Stall then flush
    no_fwd();
    id_valid = 1; id_alu_op = 3'b001; id_rs_data = 32'hCAFE0000; id_rt_data = 32'h0000BEEF;
    id_rs = 2; id_rt = 6; id_rd = 11; id_reg_dst = 0; id_alu_src = 0;
    id_reg_write = 1; id_mem_write = 1; id_mem_read = 0; id_mem_to_reg = 0;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random_id();
      step();
      check($sformatf("stall[%0d].alu_a", i), alu_a, 32'hCAFE0000);
      check($sformatf("stall[%0d].wr_reg", i), wr_reg, 6);
      check($sformatf("stall[%0d].alu_ctl", i), alu_ctl, 4'd6);
      check_all($sformatf("stall[%0d]", i));
    end
    flush = 1;
    step();
    check("flush.valid", valid, 0);
    check("flush.reg_write", reg_write, 0);
    check("flush.mem_write", mem_write, 0);
    check("flush.alu_ctl", alu_ctl, 4'd2);
    check_all("flush");
    flush = 0; stall = 0;

    // Reset mid-stream with stall asserted
    drive_random_id(); id_valid = 1; id_reg_write = 1;
    step();
    rst = 1; stall = 1;
    step();
    check("midrst.valid", valid, 0);
    check("midrst.alu_ctl", alu_ctl, 4'd2);
    check_all("midrst");
    rst = 0; stall = 0;
    drive_random_id(); id_valid = 1;
    step();
    check("postrst.valid", valid, 1);
    check_all("postrst");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_random_id();
      drive_random_fwd();
      rst   = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      step();
      check_all($sformatf("rnd[%0d]", i));
      drive_random_fwd();
      #1;
      check_all($sformatf("rnd[%0d].fwd", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
